// File: rtl/apb3_bridge_pkg.sv
// Shared definitions for the AHB-to-APB3 bridge: FSM states, HRESP codes,
// default decode table entries and sizing helpers.
package apb3_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  localparam logic [31:0] DEF_SLV_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_SLV_MASK = 32'hFFFF_F000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb3_bridge_if.sv
// AHB-side and APB-side signal bundle of the bridge; 'slave' is the bridge view,
// 'master' is the view of the surrounding system driving it.
interface apb3_bridge_if #(
  parameter int unsigned NUM_SLV = 8
) ();
  logic                   harb_apb_hsel;
  logic [31:0]            harb_xx_haddr;
  logic                   harb_xx_hwrite;
  logic [31:0]            harb_xx_hwdata;
  logic [31:0]            apb_harb_hrdata;
  logic                   apb_harb_hready;
  logic [1:0]             apb_harb_hresp;
  logic [31:0]            apb_xx_paddr;
  logic                   apb_xx_pwrite;
  logic [31:0]            apb_xx_pwdata;
  logic                   apb_xx_penable;
  logic [NUM_SLV-1:0]     psel;
  logic [NUM_SLV*32-1:0]  prdata;
  logic [NUM_SLV-1:0]     pready;
  logic [NUM_SLV-1:0]     pslverr;

  modport slave (
    input  harb_apb_hsel, harb_xx_haddr, harb_xx_hwrite, harb_xx_hwdata,
    output apb_harb_hrdata, apb_harb_hready, apb_harb_hresp,
    output apb_xx_paddr, apb_xx_pwrite, apb_xx_pwdata, apb_xx_penable, psel,
    input  prdata, pready, pslverr
  );

  modport master (
    output harb_apb_hsel, harb_xx_haddr, harb_xx_hwrite, harb_xx_hwdata,
    input  apb_harb_hrdata, apb_harb_hready, apb_harb_hresp,
    input  apb_xx_paddr, apb_xx_pwrite, apb_xx_pwdata, apb_xx_penable, psel,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb3_bridge_addr_dec.sv
// Base/mask address decoder; the lowest-numbered matching slave wins.
module apb_addr_dec
  import apb3_bridge_pkg::*;
#(
  parameter int unsigned          NUM_SLV  = 8,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE = {NUM_SLV{DEF_SLV_BASE}},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK = {NUM_SLV{DEF_SLV_MASK}},
  parameter int unsigned          IDX_W    = idx_width(NUM_SLV)
) (
  input  logic [31:0]      haddr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (!hit && ((haddr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb3_bridge.sv
// AHB-to-APB3 bridge: one outstanding transfer, registered outputs, ERROR
// response for unmapped addresses, slave errors and ACCESS timeouts.
module apb3_bridge
  import apb3_bridge_pkg::*;
#(
  parameter int unsigned           NUM_SLV  = 8,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE = {NUM_SLV{DEF_SLV_BASE}},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK = {NUM_SLV{DEF_SLV_MASK}},
  parameter int unsigned           TIMEOUT  = 256
) (
  input  logic          hclk,
  input  logic          hrst,
  apb3_bridge_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_SLV);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic             penable_q, penable_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic             hready_q, hready_d;
  hresp_t           hresp_q, hresp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             sel_ready, sel_err;
  logic [31:0]      sel_rdata;
  logic             timed_out;

  apb_addr_dec #(
    .NUM_SLV  (NUM_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IDX_W    (IDX_W)
  ) u_dec (
    .haddr (bus.harb_xx_haddr),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  assign sel_ready = bus.pready[idx_q];
  assign sel_err   = bus.pslverr[idx_q];
  assign sel_rdata = bus.prdata[32*int'(idx_q) +: 32];
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.harb_apb_hsel) begin
          if (!dec_hit)                state_d = ST_ERR1;
          else if (bus.harb_xx_hwrite) state_d = ST_LATCH;
          else                         state_d = ST_SETUP;
        end
      end
      ST_LATCH:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A ready slave takes priority over a timeout in the same cycle.
        if (sel_ready)      state_d = sel_err ? ST_ERR1 : ST_IDLE;
        else if (timed_out) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    if (state_q == ST_IDLE && bus.harb_apb_hsel) begin
      idx_d    = dec_idx;
      paddr_d  = bus.harb_xx_haddr;
      pwrite_d = bus.harb_xx_hwrite;
    end
    if (state_q == ST_LATCH) pwdata_d = bus.harb_xx_hwdata;
    if (state_q == ST_ACCESS && state_d == ST_IDLE && !pwrite_q) hrdata_d = sel_rdata;
    if (state_q == ST_SETUP) cnt_d = '0;
    else if (state_q == ST_ACCESS && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    penable_d = (state_d == ST_ACCESS);
    hready_d  = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d   = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      cnt_q     <= '0;
    end else begin
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      penable_q <= penable_d;
      hrdata_q  <= hrdata_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.psel = (state_q == ST_SETUP || state_q == ST_ACCESS)
                  ? (NUM_SLV'(1) << idx_q) : '0;
  assign bus.apb_xx_paddr    = paddr_q;
  assign bus.apb_xx_pwrite   = pwrite_q;
  assign bus.apb_xx_pwdata   = pwdata_q;
  assign bus.apb_xx_penable  = penable_q;
  assign bus.apb_harb_hrdata = hrdata_q;
  assign bus.apb_harb_hready = hready_q;
  assign bus.apb_harb_hresp  = hresp_q;

endmodule

// File: tb/tb_apb3_bridge.sv
// Bench for apb3_bridge: directed latency/protocol scenarios plus random transfers
// checked against an address-map and memory reference model.
module tb_apb3_bridge;

  localparam int unsigned NS = 4;
  localparam logic [NS*32-1:0] BASE_FLAT = {32'h4002_0000, 32'h4001_0000, 32'h4001_1000, 32'h4001_5000};
  localparam logic [NS*32-1:0] MASK_FLAT = {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic clk = 1'b0;
  logic hrst;
  always #5 clk = ~clk;

  int unsigned tests = 0, fails = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        hsel, hwrite, use_b;
  logic [31:0] haddr, hwdata;
  logic [NS-1:0]    sl_pready, sl_pslverr;
  logic [NS*32-1:0] sl_prdata;
  int unsigned wait_cfg, acc_cnt, sl_s;
  logic        err_cfg;
  logic [31:0] sl_rd;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] exp_hrdata;

  apb3_bridge_if #(.NUM_SLV(NS)) bus_a ();
  apb3_bridge_if #(.NUM_SLV(NS)) bus_b ();

  apb3_bridge #(.NUM_SLV(NS), .SLV_BASE(BASE_FLAT), .SLV_MASK(MASK_FLAT), .TIMEOUT(256))
    dut_a (.hclk(clk), .hrst(hrst), .bus(bus_a.slave));
  apb3_bridge #(.NUM_SLV(NS), .SLV_BASE(BASE_FLAT), .SLV_MASK(MASK_FLAT), .TIMEOUT(4))
    dut_b (.hclk(clk), .hrst(hrst), .bus(bus_b.slave));

  assign bus_a.harb_apb_hsel  = hsel & ~use_b;
  assign bus_b.harb_apb_hsel  = hsel & use_b;
  assign bus_a.harb_xx_haddr  = haddr;
  assign bus_b.harb_xx_haddr  = haddr;
  assign bus_a.harb_xx_hwrite = hwrite;
  assign bus_b.harb_xx_hwrite = hwrite;
  assign bus_a.harb_xx_hwdata = hwdata;
  assign bus_b.harb_xx_hwdata = hwdata;
  assign bus_a.pready  = sl_pready;
  assign bus_a.pslverr = sl_pslverr;
  assign bus_a.prdata  = sl_prdata;
  assign bus_b.pready  = '0;
  assign bus_b.pslverr = '0;
  assign bus_b.prdata  = '0;

  logic [NS-1:0] o_psel;
  logic          o_pen, o_rdy, o_pwrite;
  logic [1:0]    o_resp;
  logic [31:0]   o_paddr, o_pwdata, o_hrdata;
  assign o_psel   = use_b ? bus_b.psel : bus_a.psel;
  assign o_pen    = use_b ? bus_b.apb_xx_penable : bus_a.apb_xx_penable;
  assign o_rdy    = use_b ? bus_b.apb_harb_hready : bus_a.apb_harb_hready;
  assign o_resp   = use_b ? bus_b.apb_harb_hresp : bus_a.apb_harb_hresp;
  assign o_pwrite = use_b ? bus_b.apb_xx_pwrite : bus_a.apb_xx_pwrite;
  assign o_paddr  = use_b ? bus_b.apb_xx_paddr : bus_a.apb_xx_paddr;
  assign o_pwdata = use_b ? bus_b.apb_xx_pwdata : bus_a.apb_xx_pwdata;
  assign o_hrdata = use_b ? bus_b.apb_harb_hrdata : bus_a.apb_harb_hrdata;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  // Address map as the system sees it; earlier entries shadow later ones.
  function automatic int ref_idx(input logic [31:0] a);
    if ((a & 32'hFFFF_F000) == 32'h4001_5000) return 0;
    if ((a & 32'hFFFF_F000) == 32'h4001_1000) return 1;
    if ((a & 32'hFFFF_0000) == 32'h4001_0000) return 2;
    if ((a & 32'hFFFF_FF00) == 32'h4002_0000) return 3;
    return -1;
  endfunction

  // Cycles from address phase to hready=1 for one transfer.
  function automatic int exp_lat(input logic w, input int idx, input int waits, input logic err, input int tmo);
    int extra = w ? 1 : 0;
    if (idx < 0) return 2;
    if (tmo != 0 && waits > tmo) return 4 + tmo + extra;
    if (err) return 4 + waits + extra;
    return 3 + waits + extra;
  endfunction

  // Behavioural APB slave on bus_a; unselected lanes carry hostile values.
  always @(posedge clk) begin
    #2;
    if (bus_a.apb_xx_penable && bus_a.psel != '0) begin
      for (int i = 0; i < NS; i++) if (bus_a.psel[i]) sl_s = i;
      sl_rd = smem.exists(bus_a.apb_xx_paddr) ? smem[bus_a.apb_xx_paddr] : init_val(bus_a.apb_xx_paddr);
      sl_prdata = {NS{~sl_rd}};
      sl_prdata[32*sl_s +: 32] = sl_rd;
      sl_pslverr = '1;
      if (acc_cnt == wait_cfg) begin
        sl_pready = '1;
        sl_pslverr[sl_s] = err_cfg;
        if (bus_a.apb_xx_pwrite && !err_cfg) smem[bus_a.apb_xx_paddr] = bus_a.apb_xx_pwdata;
      end else begin
        sl_pready = ~(NS'(1) << sl_s);
        sl_pslverr[sl_s] = 1'b0;
        acc_cnt++;
      end
    end else begin
      acc_cnt    = 0;
      sl_pready  = '1;
      sl_pslverr = '1;
      sl_prdata  = {NS{$urandom}};
    end
  end

  logic [NS-1:0] psel_log [64];
  logic          pen_log [64], rdy_log [64], pwr_log [64];
  logic [1:0]    resp_log [64];
  logic [31:0]   pwd_log [64];
  int            x_lat, x_pen_cyc;
  logic [1:0]    x_resp;
  logic [NS-1:0] x_psel_or;
  logic          x_proto_ok;

  // Runs one AHB transfer starting in the current (hready=1, IDLE) cycle and logs outputs.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd);
    logic [31:0] pa0, pd0;
    logic        seen;
    hsel = 1'b1; haddr = a; hwrite = w; hwdata = $urandom;
    @(posedge clk); #1;
    hsel = 1'b0; hwdata = wd; haddr = $urandom; hwrite = 1'($urandom);
    x_lat = 0; x_pen_cyc = 0; x_psel_or = '0; x_proto_ok = 1'b1; seen = 1'b0;
    pa0 = '0; pd0 = '0;
    for (int k = 1; k < 64; k++) begin
      if (k == 2) hwdata = $urandom;
      psel_log[k] = o_psel; pen_log[k] = o_pen; rdy_log[k] = o_rdy;
      resp_log[k] = o_resp; pwd_log[k] = o_pwdata; pwr_log[k] = o_pwrite;
      if (o_psel != '0) begin
        if (!seen) begin pa0 = o_paddr; pd0 = o_pwdata; seen = 1'b1; end
        if (o_paddr !== pa0 || o_pwdata !== pd0 || o_paddr !== a || o_pwrite !== w) x_proto_ok = 1'b0;
        if ($countones(o_psel) != 1) x_proto_ok = 1'b0;
      end
      if (o_pen) begin
        x_pen_cyc++;
        if (o_psel == '0) x_proto_ok = 1'b0;
      end
      x_psel_or |= o_psel;
      if (o_rdy) begin x_lat = k; break; end
      @(posedge clk); #1;
    end
    x_resp = o_resp;
    if (x_lat != 0 && o_resp != 2'b00) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    tests++; if (bus_a.apb_harb_hready !== 1'b1) begin fails++; $display("FAIL rst_hready: got %b want 1", bus_a.apb_harb_hready); end
    tests++; if (bus_a.apb_harb_hresp !== 2'b00) begin fails++; $display("FAIL rst_hresp: got %b want 00", bus_a.apb_harb_hresp); end
    tests++; if (bus_a.psel !== '0 || bus_a.apb_xx_penable !== 1'b0) begin fails++; $display("FAIL rst_psel_pen: got %b/%b want 0/0", bus_a.psel, bus_a.apb_xx_penable); end
    tests++; if (bus_a.apb_xx_paddr !== '0 || bus_a.apb_xx_pwdata !== '0 || bus_a.apb_xx_pwrite !== 1'b0) begin fails++; $display("FAIL rst_apb_regs: got %h/%h/%b want 0", bus_a.apb_xx_paddr, bus_a.apb_xx_pwdata, bus_a.apb_xx_pwrite); end
    tests++; if (bus_a.apb_harb_hrdata !== '0) begin fails++; $display("FAIL rst_hrdata: got %h want 0", bus_a.apb_harb_hrdata); end
    hrst = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus_a.apb_harb_hready !== 1'b1 || bus_b.apb_harb_hready !== 1'b1) begin fails++; $display("FAIL idle_hready: got %b/%b want 1/1", bus_a.apb_harb_hready, bus_b.apb_harb_hready); end
  endtask

  task automatic test_read_basic();
    smem[32'h4001_5004] = 32'hA5A5_0001; rmem[32'h4001_5004] = 32'hA5A5_0001;
    wait_cfg = 0; err_cfg = 1'b0;
    xfer(32'h4001_5004, 1'b0, 32'h0);
    exp_hrdata = 32'hA5A5_0001;
    tests++; if (x_lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", x_lat); end
    tests++; if (psel_log[1] !== 4'b0001 || psel_log[2] !== 4'b0001) begin fails++; $display("FAIL rd_psel: got %b,%b want 0001,0001", psel_log[1], psel_log[2]); end
    tests++; if (pen_log[1] !== 1'b0 || pen_log[2] !== 1'b1) begin fails++; $display("FAIL rd_penable: got %b,%b want 0,1", pen_log[1], pen_log[2]); end
    tests++; if (rdy_log[1] !== 1'b0 || rdy_log[2] !== 1'b0) begin fails++; $display("FAIL rd_hready_low: got %b,%b want 0,0", rdy_log[1], rdy_log[2]); end
    tests++; if (o_hrdata !== exp_hrdata || x_resp !== 2'b00) begin fails++; $display("FAIL rd_data: got %h/%b want %h/00", o_hrdata, x_resp, exp_hrdata); end
  endtask

  task automatic test_write_basic();
    wait_cfg = 0; err_cfg = 1'b0;
    xfer(32'h4001_1008, 1'b1, 32'hDEAD_BEEF);
    rmem[32'h4001_1008] = 32'hDEAD_BEEF;
    tests++; if (x_lat !== 4 || x_resp !== 2'b00) begin fails++; $display("FAIL wr_latency: got %0d/%b want 4/00", x_lat, x_resp); end
    tests++; if (pwd_log[2] !== 32'hDEAD_BEEF || pwd_log[3] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_pwdata: got %h,%h want deadbeef", pwd_log[2], pwd_log[3]); end
    tests++; if (pwr_log[2] !== 1'b1 || pwr_log[3] !== 1'b1 || psel_log[2] !== 4'b0010) begin fails++; $display("FAIL wr_pwrite_psel: got %b,%b,%b want 1,1,0010", pwr_log[2], pwr_log[3], psel_log[2]); end
    tests++; if (smem[32'h4001_1008] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_slave_mem: got %h want deadbeef", smem[32'h4001_1008]); end
    tests++; if (o_hrdata !== exp_hrdata) begin fails++; $display("FAIL wr_hrdata_hold: got %h want %h", o_hrdata, exp_hrdata); end
  endtask

  task automatic test_wait_states();
    wait_cfg = 5; err_cfg = 1'b0;
    xfer(32'h4001_1008, 1'b0, 32'h0);
    exp_hrdata = 32'hDEAD_BEEF;
    tests++; if (x_lat !== 8 || x_pen_cyc !== 6) begin fails++; $display("FAIL wait_timing: got lat %0d access %0d want 8/6", x_lat, x_pen_cyc); end
    tests++; if (x_proto_ok !== 1'b1) begin fails++; $display("FAIL wait_stable: got %b want 1", x_proto_ok); end
    tests++; if (o_hrdata !== exp_hrdata || x_resp !== 2'b00) begin fails++; $display("FAIL wait_data: got %h/%b want %h/00", o_hrdata, x_resp, exp_hrdata); end
    wait_cfg = 0;
  endtask

  task automatic test_unmapped();
    xfer(32'h5000_0000, 1'b0, 32'h0);
    tests++; if (x_psel_or !== '0) begin fails++; $display("FAIL unmap_psel: got %b want 0000", x_psel_or); end
    tests++; if (resp_log[1] !== 2'b01 || rdy_log[1] !== 1'b0) begin fails++; $display("FAIL unmap_err1: got %b/%b want 01/0", resp_log[1], rdy_log[1]); end
    tests++; if (x_lat !== 2 || x_resp !== 2'b01) begin fails++; $display("FAIL unmap_err2: got %0d/%b want 2/01", x_lat, x_resp); end
    tests++; if (o_hrdata !== exp_hrdata) begin fails++; $display("FAIL unmap_hrdata: got %h want %h", o_hrdata, exp_hrdata); end
  endtask

  task automatic test_slverr();
    wait_cfg = 1; err_cfg = 1'b1;
    xfer(32'h4002_0010, 1'b0, 32'h0);
    tests++; if (x_lat !== 5 || x_resp !== 2'b01) begin fails++; $display("FAIL slverr_resp: got %0d/%b want 5/01", x_lat, x_resp); end
    tests++; if (resp_log[4] !== 2'b01 || rdy_log[4] !== 1'b0 || psel_log[3] !== 4'b1000) begin fails++; $display("FAIL slverr_seq: got %b/%b/%b want 01/0/1000", resp_log[4], rdy_log[4], psel_log[3]); end
    tests++; if (o_hrdata !== exp_hrdata) begin fails++; $display("FAIL slverr_hrdata: got %h want %h", o_hrdata, exp_hrdata); end
    wait_cfg = 0; err_cfg = 1'b0;
  endtask

  task automatic test_timeout();
    use_b = 1'b1;
    xfer(32'h4001_5010, 1'b0, 32'h0);
    tests++; if (x_lat !== 8 || x_resp !== 2'b01) begin fails++; $display("FAIL tmo_resp: got %0d/%b want 8/01", x_lat, x_resp); end
    tests++; if (x_pen_cyc !== 5) begin fails++; $display("FAIL tmo_access_cycles: got %0d want 5", x_pen_cyc); end
    tests++; if (psel_log[7] !== '0 || pen_log[7] !== 1'b0 || resp_log[7] !== 2'b01 || rdy_log[7] !== 1'b0) begin fails++; $display("FAIL tmo_drop: got %b/%b/%b/%b want 0000/0/01/0", psel_log[7], pen_log[7], resp_log[7], rdy_log[7]); end
    tests++; if (o_hrdata !== '0) begin fails++; $display("FAIL tmo_hrdata: got %h want 0", o_hrdata); end
    use_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned c0;
    logic [31:0] wd;
    wd = $urandom;
    c0 = cyc;
    xfer(32'h4001_0200, 1'b1, wd);
    rmem[32'h4001_0200] = wd;
    xfer(32'h4001_0200, 1'b0, 32'h0);
    exp_hrdata = wd;
    tests++; if (cyc - c0 !== 7) begin fails++; $display("FAIL b2b_wr_rd_cycles: got %0d want 7", cyc - c0); end
    tests++; if (o_hrdata !== exp_hrdata || x_lat !== 3) begin fails++; $display("FAIL b2b_readback: got %h/%0d want %h/3", o_hrdata, x_lat, exp_hrdata); end
    c0 = cyc;
    xfer(32'h4001_5004, 1'b0, 32'h0);
    xfer(32'h4001_1008, 1'b0, 32'h0);
    exp_hrdata = rmem[32'h4001_1008];
    tests++; if (cyc - c0 !== 6) begin fails++; $display("FAIL b2b_rd_rd_cycles: got %0d want 6", cyc - c0); end
    tests++; if (o_hrdata !== exp_hrdata) begin fails++; $display("FAIL b2b_rd_data: got %h want %h", o_hrdata, exp_hrdata); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp_rd;
    logic        w, err;
    int          idx, waits, sel;
    logic [1:0]  eresp;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: a = 32'h4001_5000 | ($urandom & 32'hFFC);
        1: a = 32'h4001_1000 | ($urandom & 32'hFFC);
        2: a = 32'h4001_0000 | ($urandom & 32'hFFFC);
        3: a = 32'h4002_0000 | ($urandom & 32'hFC);
        default: a = 32'h6000_0000 | ($urandom & 32'hFFFF_FFC);
      endcase
      w = 1'($urandom); wd = $urandom;
      waits = $urandom_range(0, 3); err = ($urandom_range(0, 9) == 0);
      wait_cfg = waits; err_cfg = err;
      idx = ref_idx(a);
      xfer(a, w, wd);
      eresp = (idx < 0 || err) ? 2'b01 : 2'b00;
      exp_rd = rmem.exists(a) ? rmem[a] : init_val(a);
      if (eresp == 2'b00) begin
        if (w) rmem[a] = wd;
        else   exp_hrdata = exp_rd;
      end
      tests++; if (x_lat !== exp_lat(w, idx, waits, err, 256)) begin fails++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, x_lat, exp_lat(w, idx, waits, err, 256)); end
      tests++; if (x_resp !== eresp) begin fails++; $display("FAIL rnd_hresp[%0d]: got %b want %b", n, x_resp, eresp); end
      tests++; if (o_hrdata !== exp_hrdata) begin fails++; $display("FAIL rnd_hrdata[%0d]: got %h want %h", n, o_hrdata, exp_hrdata); end
      tests++; if (x_psel_or !== ((idx < 0) ? 4'b0000 : (4'b0001 << idx))) begin fails++; $display("FAIL rnd_psel[%0d]: got %b want idx %0d", n, x_psel_or, idx); end
      tests++; if (x_proto_ok !== 1'b1) begin fails++; $display("FAIL rnd_protocol[%0d]: got %b want 1", n, x_proto_ok); end
    end
    wait_cfg = 0; err_cfg = 1'b0;
  endtask

  task automatic test_reset_mid();
    wait_cfg = 10;
    hsel = 1'b1; haddr = 32'h4001_5008; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus_a.apb_xx_penable !== 1'b1 || bus_a.psel !== 4'b0001) begin fails++; $display("FAIL mid_in_access: got %b/%b want 1/0001", bus_a.apb_xx_penable, bus_a.psel); end
    hrst = 1'b1;
    #1;
    tests++; if (bus_a.psel !== '0 || bus_a.apb_xx_penable !== 1'b0) begin fails++; $display("FAIL mid_rst_apb: got %b/%b want 0000/0", bus_a.psel, bus_a.apb_xx_penable); end
    tests++; if (bus_a.apb_harb_hready !== 1'b1 || bus_a.apb_harb_hresp !== 2'b00) begin fails++; $display("FAIL mid_rst_ahb: got %b/%b want 1/00", bus_a.apb_harb_hready, bus_a.apb_harb_hresp); end
    tests++; if (bus_a.apb_xx_paddr !== '0 || bus_a.apb_xx_pwdata !== '0 || bus_a.apb_xx_pwrite !== 1'b0 || bus_a.apb_harb_hrdata !== '0) begin fails++; $display("FAIL mid_rst_regs: got %h/%h/%b/%h want 0", bus_a.apb_xx_paddr, bus_a.apb_xx_pwdata, bus_a.apb_xx_pwrite, bus_a.apb_harb_hrdata); end
    @(posedge clk); #1;
    hrst = 1'b0; wait_cfg = 0;
    @(posedge clk); #1;
    exp_hrdata = '0;
    xfer(32'h4001_5004, 1'b0, 32'h0);
    exp_hrdata = rmem[32'h4001_5004];
    tests++; if (x_lat !== 3 || o_hrdata !== exp_hrdata) begin fails++; $display("FAIL post_rst_read: got %0d/%h want 3/%h", x_lat, o_hrdata, exp_hrdata); end
  endtask

  initial begin
    hrst = 1'b1; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0; use_b = 1'b0;
    wait_cfg = 0; err_cfg = 1'b0; acc_cnt = 0; sl_s = 0; sl_rd = '0;
    sl_pready = '1; sl_pslverr = '1; sl_prdata = '0; exp_hrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_wait_states();
    test_unmapped();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb3_bridge.md
APB3_BRIDGE -- requirements
Module: apb3_bridge

Interface
REQ-001 SHALL have parameter NUM_SLV, default 8, meaning APB slave count (1..16).
REQ-002 SHALL have parameter SLV_BASE, default {NUM_SLV x 32'h0}, meaning flat per-slave base address, slave i at bits [32i+31:32i].
REQ-003 SHALL have parameter SLV_MASK, default {NUM_SLV x 32'hFFFFF000}, meaning flat per-slave compare mask.
REQ-004 SHALL have parameter TIMEOUT, default 256, meaning maximum ACCESS wait cycles; 0 disables the timeout.
REQ-005 SHALL have ports (one clock; reset is asynchronous and active-high):
 hclk  in  1  clock
 hrst  in  1  asynchronous active-high reset
 harb_apb_hsel  in  1  AHB select, address phase
 harb_xx_haddr  in  32  AHB address
 harb_xx_hwrite  in  1  AHB write
 harb_xx_hwdata  in  32  AHB write data, data phase
 apb_harb_hrdata  out  32  read data
 apb_harb_hready  out  1  transfer done
 apb_harb_hresp  out  2  00 OKAY, 01 ERROR
 apb_xx_paddr  out  32  APB address
 apb_xx_pwrite  out  1  APB write
 apb_xx_pwdata  out  32  APB write data
 apb_xx_penable  out  1  APB enable
 psel  out  NUM_SLV  one-hot slave select
 prdata  in  NUM_SLV*32  flat slave read data
 pready  in  NUM_SLV  slave ready
 pslverr  in  NUM_SLV  slave error

Function
REQ-006 SHALL decode slave i hit as (haddr & MASK_i) == BASE_i; lowest index wins on overlap; no hit = unmapped.
REQ-007 SHALL use states IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
REQ-008 IDLE SHALL accept on hsel=1: mapped write -> LATCH, mapped read -> SETUP, unmapped -> ERR1 with no APB cycle; haddr, hwrite and slave index SHALL be registered.
REQ-009 LATCH SHALL capture hwdata into pwdata, then go to SETUP.
REQ-010 SETUP SHALL drive psel[idx]=1 and penable=0, then go to ACCESS.
REQ-011 ACCESS SHALL drive psel[idx]=1 and penable=1, and hold paddr, pwrite and pwdata stable while pready[idx]=0.
REQ-012 In ACCESS, pready[idx]=1 with pslverr[idx]=0 SHALL register prdata[idx] into hrdata and go to IDLE.
REQ-013 In ACCESS, pready[idx]=1 with pslverr[idx]=1 SHALL go to ERR1.
REQ-014 In ACCESS, the wait counter reaching TIMEOUT SHALL go to ERR1 and drop psel/penable.
REQ-015 The wait counter SHALL clear on ACCESS entry and saturate; its width SHALL be clog2(TIMEOUT+1).
REQ-016 ERR1 SHALL drive hready=0 and hresp=01; ERR2 SHALL drive hready=1 and hresp=01; ERR2 SHALL go to IDLE.
REQ-017 hready SHALL be 1 in IDLE and ERR2 only; hresp SHALL be 00 outside ERR1/ERR2.
REQ-018 hrdata SHALL hold its last value; it SHALL not update on writes or on errors.
REQ-019 Read latency SHALL be 3 cycles from address phase to hready=1 with zero-wait slaves; write latency SHALL be 4 cycles.
REQ-020 A new hsel in the IDLE cycle with hready=1 SHALL be accepted back-to-back.
REQ-021 psel SHALL be one-hot or zero; penable=1 SHALL occur only with psel != 0.
REQ-022 All outputs SHALL be registered, except psel, which is decoded from the registered index and state.

Reset
REQ-023 hrst=1 SHALL force IDLE, hready=1, hresp=00, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, counter=0, immediately, including mid-transfer.

Structure
REQ-024 State encodings, HRESP codes and the default base/mask tables SHALL reside in the shared apb include file.
REQ-025 Address decode SHALL be sub-module apb_addr_dec (haddr -> hit, idx).

Verification
REQ-026 Read 0x40015004, slave 0 pready=1, prdata=0xA5A5_0001 -> psel[0] in cycles 1-2, penable in cycle 2, hready=1 with hrdata=0xA5A5_0001 in cycle 3.
REQ-027 Write 0x40011008 with hwdata=0xDEAD_BEEF -> pwdata=0xDEAD_BEEF and pwrite=1 in SETUP/ACCESS, hready in cycle 4, hresp=00.
REQ-028 Read with pready low for 5 cycles -> ACCESS held 6 cycles with signals stable, then OKAY.
REQ-029 Unmapped 0x50000000 -> no psel, hresp=01 with hready 0 then 1.
REQ-030 pslverr=1 case and TIMEOUT=4 with pready stuck at 0 -> ERROR response; hrst pulse in ACCESS -> all outputs at reset values the same cycle.
